// File: rtl/aurora_reset_sequencer.sv
// ============================================================================
// aurora_reset_sequencer
//
// Purpose:
//   Drives the reset pins of an Aurora 64B/66B core in the order the core
//   expects: reset_pb is raised first, pma_init is pulsed while reset_pb is
//   held, and reset_pb is released some time after pma_init falls. The three
//   phase lengths are parameters. The block can run one sequence on its own
//   when resetn deasserts, reports busy/done, and counts the sequences it
//   starts.
//
//   Optional feature macro: AURORA_RESET_WATCHDOG_EN
//     When defined, the block waits for channel_up after each sequence. If
//     channel_up does not arrive within UP_TIMEOUT_CYCLES clocks, the whole
//     sequence runs again, with no limit on the number of retries. When the
//     macro is undefined, channel_up is ignored and no timeout counter is
//     built.
//
// Ports:
//   clock         in   system clock, all logic on the rising edge
//   resetn        in   asynchronous active-low block reset
//   resetn_in     in   synchronous active-low sequence request (level, IDLE only)
//   channel_up    in   Aurora channel_up (watchdog build only)
//   reset_pb_out  out  Aurora reset_pb, active high
//   pma_init_out  out  Aurora pma_init, active high
//   busy          out  high whenever the sequencer is not idle
//   seq_done      out  one-cycle pulse when a sequence completes
//   seq_count     out  sequences started since resetn, saturating at 255
// ============================================================================
module aurora_reset_sequencer #(
    parameter int unsigned CNT_W             = 32,
    parameter int unsigned PB_LEAD_CYCLES    = 128,
    parameter int unsigned PMA_HOLD_CYCLES   = 1000000,
    parameter int unsigned PB_TRAIL_CYCLES   = 10000,
    parameter bit          AUTO_START        = 1'b1,
    parameter int unsigned UP_TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       resetn_in,
    input  logic       channel_up,
    output logic       reset_pb_out,
    output logic       pma_init_out,
    output logic       busy,
    output logic       seq_done,
    output logic [7:0] seq_count
);

    // The phase counter counts down to zero and the phase ends on the edge
    // after it reaches zero, so each phase loads N-1. A length of 0 loads 0
    // and therefore lasts one clock.
    localparam logic [CNT_W-1:0] LEAD_LOAD  =
        (PB_LEAD_CYCLES  > 1) ? CNT_W'(PB_LEAD_CYCLES  - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LOAD  =
        (PMA_HOLD_CYCLES > 1) ? CNT_W'(PMA_HOLD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] TRAIL_LOAD =
        (PB_TRAIL_CYCLES > 1) ? CNT_W'(PB_TRAIL_CYCLES - 1) : '0;

`ifdef AURORA_RESET_WATCHDOG_EN
    localparam logic [CNT_W-1:0] UP_LOAD =
        (UP_TIMEOUT_CYCLES > 1) ? CNT_W'(UP_TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        PB_LEAD,
        PMA_HOLD,
        PB_TRAIL,
        WAIT_UP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        PB_LEAD,
        PMA_HOLD,
        PB_TRAIL
    } state_t;

    // channel_up and the timeout only matter in the watchdog build.
    logic unused_watchdog;
    assign unused_watchdog = channel_up ^ (UP_TIMEOUT_CYCLES != 0);
`endif

    localparam state_t RESET_STATE = AUTO_START ? PB_LEAD : IDLE;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pb_nxt;
    logic             pma_nxt;
    logic             done_nxt;
    logic             busy_nxt;
    logic [7:0]       count_nxt;
    logic             count_up;

    // An auto-started sequence counts as started on the first edge after
    // reset releases. This flag carries that one deferred increment.
    logic             auto_pending;

    // Next-state and next-output logic. Every output is computed here for the
    // following cycle and registered below, so the core sees clean levels.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pb_nxt    = reset_pb_out;
        pma_nxt   = pma_init_out;
        done_nxt  = 1'b0;
        count_up  = auto_pending;

        case (state)
            IDLE: begin
                pb_nxt  = 1'b0;
                pma_nxt = 1'b0;
                if (!resetn_in) begin
                    state_nxt = PB_LEAD;
                    pb_nxt    = 1'b1;
                    cnt_nxt   = LEAD_LOAD;
                    count_up  = 1'b1;
                end
            end

            PB_LEAD: begin
                if (cnt == '0) begin
                    state_nxt = PMA_HOLD;
                    pma_nxt   = 1'b1;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            PMA_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = PB_TRAIL;
                    pma_nxt   = 1'b0;
                    cnt_nxt   = TRAIL_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            PB_TRAIL: begin
                if (cnt == '0) begin
                    pb_nxt = 1'b0;
`ifdef AURORA_RESET_WATCHDOG_EN
                    state_nxt = WAIT_UP;
                    cnt_nxt   = UP_LOAD;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

`ifdef AURORA_RESET_WATCHDOG_EN
            // channel_up wins over a timeout that expires on the same edge.
            WAIT_UP: begin
                if (channel_up) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = PB_LEAD;
                    pb_nxt    = 1'b1;
                    cnt_nxt   = LEAD_LOAD;
                    count_up  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
                pb_nxt    = 1'b0;
                pma_nxt   = 1'b0;
            end
        endcase

        busy_nxt  = (state_nxt != IDLE);
        count_nxt = (count_up && (seq_count != 8'hFF)) ? seq_count + 8'd1 : seq_count;
    end

    // State and output registers. Reset holds the core in reset_pb with
    // pma_init low and preloads the lead phase so auto-start begins on release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= RESET_STATE;
            cnt          <= LEAD_LOAD;
            reset_pb_out <= 1'b1;
            pma_init_out <= 1'b0;
            busy         <= AUTO_START;
            seq_done     <= 1'b0;
            seq_count    <= 8'd0;
            auto_pending <= AUTO_START;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            reset_pb_out <= pb_nxt;
            pma_init_out <= pma_nxt;
            busy         <= busy_nxt;
            seq_done     <= done_nxt;
            seq_count    <= count_nxt;
            auto_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// ============================================================================
// tb_aurora_reset_sequencer
//
// Purpose:
//   Self-checking bench for aurora_reset_sequencer. It runs one auto-start
//   instance and one request-driven instance side by side. Expected output
//   edges, each with a cycle, a seq_count value and a busy value, go into a
//   queue per instance. A negedge monitor turns every observed edge into an
//   event and compares it with the head of that instance's queue.
//   Build with AURORA_RESET_WATCHDOG_EN defined to exercise the watchdog.
//
// Ports: none (top-level bench).
// ============================================================================
module tb_aurora_reset_sequencer;

    localparam int LEAD  = 4;
    localparam int HOLD  = 20;
    localparam int TRAIL = 8;
    localparam int UPTO  = 50;
`ifdef AURORA_RESET_WATCHDOG_EN
    localparam int WD = 1;
`else
    localparam int WD = 0;
`endif
    // Spacing between starts of back-to-back sequences.
    localparam int PERIOD = LEAD + HOLD + TRAIL + WD + 1;

    localparam int PB_RISE   = 0;
    localparam int PMA_RISE  = 1;
    localparam int PMA_FALL  = 2;
    localparam int PB_FALL   = 3;
    localparam int DONE_RISE = 4;
    localparam int DONE_FALL = 5;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int busy;
    } evt_t;

    logic       clock;
    logic       resetn;
    logic       reqMan;
    logic       chUpAuto;
    logic       pbAuto, pmaAuto, busyAuto, doneAuto;
    logic       pbMan, pmaMan, busyMan, doneMan;
    logic [7:0] cntAuto, cntMan;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    evt_t expAuto[$];
    evt_t expMan[$];
    bit   armed[2];
    bit   prevPb[2], prevPma[2], prevDone[2];

    aurora_reset_sequencer #(
        .CNT_W(16), .PB_LEAD_CYCLES(LEAD), .PMA_HOLD_CYCLES(HOLD),
        .PB_TRAIL_CYCLES(TRAIL), .AUTO_START(1'b1), .UP_TIMEOUT_CYCLES(UPTO)
    ) dutAuto (
        .clock(clock), .resetn(resetn), .resetn_in(1'b1), .channel_up(chUpAuto),
        .reset_pb_out(pbAuto), .pma_init_out(pmaAuto), .busy(busyAuto),
        .seq_done(doneAuto), .seq_count(cntAuto)
    );

    aurora_reset_sequencer #(
        .CNT_W(16), .PB_LEAD_CYCLES(LEAD), .PMA_HOLD_CYCLES(HOLD),
        .PB_TRAIL_CYCLES(TRAIL), .AUTO_START(1'b0), .UP_TIMEOUT_CYCLES(UPTO)
    ) dutMan (
        .clock(clock), .resetn(resetn), .resetn_in(reqMan), .channel_up(1'b1),
        .reset_pb_out(pbMan), .pma_init_out(pmaMan), .busy(busyMan),
        .seq_done(doneMan), .seq_count(cntMan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            PB_RISE:   return "pb_rise";
            PMA_RISE:  return "pma_rise";
            PMA_FALL:  return "pma_fall";
            PB_FALL:   return "pb_fall";
            DONE_RISE: return "done_rise";
            default:   return "done_fall";
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Insert keeps each queue ordered by cycle, then by the order in which
    // the monitor reports edges within one cycle.
    function automatic void pushExp(input int man, input int kind, input int c,
                                    input int cnt, input int busy);
        evt_t e;
        int   i;
        e.kind = kind;
        e.cyc  = c;
        e.cnt  = cnt;
        e.busy = busy;
        if (man != 0) begin
            i = expMan.size();
            while (i > 0 && (expMan[i-1].cyc > c ||
                   (expMan[i-1].cyc == c && expMan[i-1].kind > kind))) i--;
            expMan.insert(i, e);
        end else begin
            i = expAuto.size();
            while (i > 0 && (expAuto[i-1].cyc > c ||
                   (expAuto[i-1].cyc == c && expAuto[i-1].kind > kind))) i--;
            expAuto.insert(i, e);
        end
    endfunction

    // Expected edges of one full sequence whose lead phase starts at edge t.
    function automatic void pushSeq(input int man, input int t, input int cnt,
                                    input bit pbRise, input bit nextStarts);
        int pmaUp, pmaDn, pbDn, dn;
        pmaUp = t + LEAD;
        pmaDn = pmaUp + HOLD;
        pbDn  = pmaDn + TRAIL;
        dn    = pbDn + WD;
        if (pbRise) pushExp(man, PB_RISE, t, cnt, 1);
        pushExp(man, PMA_RISE, pmaUp, cnt, 1);
        pushExp(man, PMA_FALL, pmaDn, cnt, 1);
        pushExp(man, PB_FALL, pbDn, cnt, WD);
        pushExp(man, DONE_RISE, dn, cnt, 0);
        pushExp(man, DONE_FALL, dn + 1, nextStarts ? sat(cnt + 1) : cnt,
                nextStarts ? 1 : 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic checkEvent(input int man, input int kind, input int cnt,
                              input int busy);
        evt_t  e;
        string inst;
        inst = (man != 0) ? "man" : "auto";
        if ((man != 0) ? (expMan.size() == 0) : (expAuto.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s unexpected %s: got cycle %0d, expected no event",
                     inst, kindName(kind), cyc);
        end else begin
            if (man != 0) e = expMan.pop_front();
            else          e = expAuto.pop_front();
            checkOutput($sformatf("%s %s kind", inst, kindName(e.kind)), kind, e.kind);
            checkOutput($sformatf("%s %s cycle", inst, kindName(e.kind)), cyc, e.cyc);
            checkOutput($sformatf("%s %s seq_count", inst, kindName(e.kind)), cnt, e.cnt);
            checkOutput($sformatf("%s %s busy", inst, kindName(e.kind)), busy, e.busy);
        end
    endtask

    task automatic monitorStep(input int man, input logic pb, input logic pma,
                               input logic done, input logic busy,
                               input logic [7:0] cnt);
        if (armed[man]) begin
            if ( pb   && !prevPb[man])   checkEvent(man, PB_RISE,   int'(cnt), int'(busy));
            if ( pma  && !prevPma[man])  checkEvent(man, PMA_RISE,  int'(cnt), int'(busy));
            if (!pma  &&  prevPma[man])  checkEvent(man, PMA_FALL,  int'(cnt), int'(busy));
            if (!pb   &&  prevPb[man])   checkEvent(man, PB_FALL,   int'(cnt), int'(busy));
            if ( done && !prevDone[man]) checkEvent(man, DONE_RISE, int'(cnt), int'(busy));
            if (!done &&  prevDone[man]) checkEvent(man, DONE_FALL, int'(cnt), int'(busy));
            checkOutput((man != 0) ? "man pma implies pb" : "auto pma implies pb",
                        {31'd0, pma & ~pb}, 32'd0);
        end
        armed[man]    = 1'b1;
        prevPb[man]   = pb;
        prevPma[man]  = pma;
        prevDone[man] = done;
    endtask

    always @(negedge clock) begin
        monitorStep(0, pbAuto, pmaAuto, doneAuto, busyAuto, cntAuto);
        monitorStep(1, pbMan, pmaMan, doneMan, busyMan, cntMan);
    end

    task automatic waitNeg(input int c);
        @(negedge clock);
        while (cyc < c) @(negedge clock);
    endtask

    // Inputs change on the negedge where cyc == atCyc and are sampled by
    // edge atCyc+1.
    task automatic applyStimulus(input int atCyc, input logic rn, input logic rq,
                                 input logic cu);
        waitNeg(atCyc);
        resetn   = rn;
        reqMan   = rq;
        chUpAuto = cu;
    endtask

    initial begin
        int r, t1, u, v, t, r2;
        resetn   = 1'b0;
        reqMan   = 1'b1;
        chUpAuto = 1'b0;

        // Values held while in reset.
        waitNeg(2);
        checkOutput("auto reset reset_pb", pbAuto, 1);
        checkOutput("auto reset pma_init", pmaAuto, 0);
        checkOutput("auto reset busy", busyAuto, 1);
        checkOutput("auto reset seq_done", doneAuto, 0);
        checkOutput("auto reset seq_count", cntAuto, 0);
        checkOutput("man reset reset_pb", pbMan, 1);
        checkOutput("man reset pma_init", pmaMan, 0);
        checkOutput("man reset busy", busyMan, 0);
        checkOutput("man reset seq_done", doneMan, 0);
        checkOutput("man reset seq_count", cntMan, 0);

        // Release: auto instance sequences; manual instance drops reset_pb.
        r = 3;
`ifdef AURORA_RESET_WATCHDOG_EN
        pushExp(0, PMA_RISE, r + 4, 1, 1);
        pushExp(0, PMA_FALL, r + 24, 1, 1);
        pushExp(0, PB_FALL, r + 32, 1, 1);
        pushSeq(0, r + 32 + UPTO, 2, 1'b1, 1'b0);
`else
        pushSeq(0, r, 1, 1'b0, 1'b0);
`endif
        pushExp(1, PB_FALL, r + 1, 0, 0);
        applyStimulus(r, 1'b1, 1'b1, 1'b0);
        // channel_up rises in the second WAIT_UP of the watchdog build.
        applyStimulus(r + 114, 1'b1, 1'b1, 1'b1);

        // Single one-cycle request.
        pushSeq(1, 131, 1, 1'b1, 1'b0);
        applyStimulus(130, 1'b1, 1'b0, 1'b1);
        applyStimulus(131, 1'b1, 1'b1, 1'b1);

        // Request held low: back-to-back sequences, one IDLE cycle apart.
        t1 = 171;
        pushSeq(1, t1, 2, 1'b1, 1'b1);
        pushSeq(1, t1 + PERIOD, 3, 1'b1, 1'b0);
        applyStimulus(t1 - 1, 1'b1, 1'b0, 1'b1);
        applyStimulus(t1 + PERIOD + 5, 1'b1, 1'b1, 1'b1);

        // Saturation: counts 4..255, then one more that stays at 255.
        u = t1 + 2 * PERIOD + 5;
        for (int k = 0; k < 253; k++)
            pushSeq(1, u + 1 + k * PERIOD, sat(4 + k), 1'b1, (k < 252));
        applyStimulus(u, 1'b1, 1'b0, 1'b1);
        applyStimulus(u + 1 + 252 * PERIOD + 5, 1'b1, 1'b1, 1'b1);

        // resetn asserted mid PMA_HOLD takes effect without a clock edge.
        v = u + 1 + 253 * PERIOD + 5;
        t = v + 1;
        pushExp(1, PB_RISE, t, 255, 1);
        pushExp(1, PMA_RISE, t + 4, 255, 1);
        pushExp(1, PMA_FALL, t + 10, 0, 0);
        pushExp(0, PB_RISE, t + 10, 0, 1);
        applyStimulus(v, 1'b1, 1'b0, 1'b1);
        applyStimulus(v + 1, 1'b1, 1'b1, 1'b1);
        waitNeg(t + 9);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async man pma_init", pmaMan, 0);
        checkOutput("async man reset_pb", pbMan, 1);
        checkOutput("async man seq_count", cntMan, 0);
        checkOutput("async man busy", busyMan, 0);
        checkOutput("async auto reset_pb", pbAuto, 1);
        checkOutput("async auto busy", busyAuto, 1);
        checkOutput("async auto seq_count", cntAuto, 0);

        r2 = t + 14;
        pushSeq(0, r2, 1, 1'b0, 1'b0);
        pushExp(1, PB_FALL, r2 + 1, 0, 0);
        applyStimulus(r2, 1'b1, 1'b1, 1'b1);
        waitNeg(r2 + 60);

        while (expAuto.size() > 0) begin
            evt_t e;
            e = expAuto.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL auto missing %s: got none, expected cycle %0d",
                     kindName(e.kind), e.cyc);
        end
        while (expMan.size() > 0) begin
            evt_t e;
            e = expMan.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL man missing %s: got none, expected cycle %0d",
                     kindName(e.kind), e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
